// File: rtl/mem_bus_arbiter.sv
// N-port request/grant arbiter in front of a single-port word RAM.
// Round-robin or fixed priority, address-window decode, fixed-latency in-order responses.
module mem_bus_arbiter #(
  parameter int                   NumPorts   = 2,
  parameter int                   AddrWidth  = 32,
  parameter int                   DataWidth  = 32,
  parameter int                   Depth      = 16384,
  parameter logic [AddrWidth-1:0] AddrBase   = '0,
  parameter int                   MemLatency = 1,
  parameter int                   FixedPrio  = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumPorts-1:0]               req_i,
  output logic [NumPorts-1:0]               gnt_o,
  input  logic [NumPorts-1:0]               we_i,
  input  logic [NumPorts*DataWidth/8-1:0]   be_i,
  input  logic [NumPorts*AddrWidth-1:0]     addr_i,
  input  logic [NumPorts*DataWidth-1:0]     wdata_i,
  output logic [NumPorts-1:0]               rvalid_o,
  output logic [NumPorts-1:0]               err_o,
  output logic [DataWidth-1:0]              rdata_o,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [DataWidth/8-1:0]            mem_be_o,
  output logic [$clog2(Depth)-1:0]          mem_addr_o,
  output logic [DataWidth-1:0]              mem_wdata_o,
  input  logic                              mem_rvalid_i,
  input  logic [DataWidth-1:0]              mem_rdata_i,
  output logic                              protocol_err_o
);

  localparam int         BeW      = DataWidth / 8;
  localparam int         PortW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int         MemAw    = $clog2(Depth);
  localparam int         OffShift = $clog2(BeW);
  localparam int         Head     = MemLatency - 1;
  localparam int         SupW     = $clog2(MemLatency + 1);
  localparam logic [64:0] WinBytes = 65'(Depth) * 65'(BeW);

  logic [BeW-1:0]       be_arr    [NumPorts];
  logic [AddrWidth-1:0] addr_arr  [NumPorts];
  logic [DataWidth-1:0] wdata_arr [NumPorts];

  for (genvar p = 0; p < NumPorts; p++) begin : g_unpack
    assign be_arr[p]    = be_i[p*BeW +: BeW];
    assign addr_arr[p]  = addr_i[p*AddrWidth +: AddrWidth];
    assign wdata_arr[p] = wdata_i[p*DataWidth +: DataWidth];
  end

  logic [PortW-1:0] rr_q;
  logic [PortW-1:0] gnt_idx;
  logic             gnt_any;

  // Search starts one past the last winner in round-robin mode, at port 0 in fixed mode.
  always_comb begin
    int               cand;
    logic [PortW-1:0] cand_w;
    cand    = 0;
    cand_w  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NumPorts; k++) begin
      cand   = (FixedPrio != 0) ? k : (int'(rr_q) + 1 + k) % NumPorts;
      cand_w = PortW'(cand);
      if (!gnt_any && req_i[cand_w]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_w;
      end
    end
    if (rst_i) gnt_any = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        rr_q <= PortW'(NumPorts - 1);
    else if (gnt_any) rr_q <= gnt_idx;
  end

  logic [AddrWidth-1:0] off;
  logic                 in_win;

  assign off    = addr_arr[gnt_idx] - AddrBase;
  assign in_win = 65'(off) < WinBytes;

  assign gnt_o       = gnt_any ? (NumPorts'(1) << gnt_idx) : '0;
  assign mem_req_o   = gnt_any & in_win;
  assign mem_we_o    = mem_req_o & we_i[gnt_idx];
  assign mem_be_o    = mem_req_o ? be_arr[gnt_idx] : '0;
  assign mem_addr_o  = mem_req_o ? MemAw'(off >> OffShift) : '0;
  assign mem_wdata_o = mem_req_o ? wdata_arr[gnt_idx] : '0;

  // Response pipeline: stage 0 loaded at grant, stage Head lines up with mem_rvalid_i.
  logic             vld_p  [MemLatency];
  logic [PortW-1:0] port_p [MemLatency];
  logic             err_p  [MemLatency];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MemLatency; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= gnt_any;
      for (int i = 1; i < MemLatency; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    port_p[0] <= gnt_idx;
    err_p[0]  <= ~in_win;
    for (int i = 1; i < MemLatency; i++) begin
      port_p[i] <= port_p[i-1];
      err_p[i]  <= err_p[i-1];
    end
  end

  logic head_vld;

  assign head_vld = vld_p[Head] & ~rst_i;
  assign rvalid_o = head_vld ? (NumPorts'(1) << port_p[Head]) : '0;
  assign err_o    = (head_vld & err_p[Head]) ? (NumPorts'(1) << port_p[Head]) : '0;
  assign rdata_o  = (head_vld & ~err_p[Head]) ? mem_rdata_i : '0;

  // Stale RAM responses from before reset can still arrive for MemLatency cycles.
  logic [SupW-1:0] sup_q;
  logic            perr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sup_q  <= SupW'(MemLatency);
      perr_q <= 1'b0;
    end else if (sup_q != '0) begin
      sup_q <= sup_q - 1'b1;
    end else if ((vld_p[Head] & ~err_p[Head]) != mem_rvalid_i) begin
      perr_q <= 1'b1;
    end
  end

  assign protocol_err_o = perr_q;

endmodule
